// File: rtl/demux_route_scheduler.sv
// demux_route_scheduler
// Buffers routing requests (destination + data bit) in a small FIFO and
// replays them one at a time onto the 1-to-4 demux control inputs. Each
// request is held for HOLD cycles, and queued requests follow back-to-back.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - request present
//   in_ready   - request can be accepted this cycle (combinational)
//   in_dest    - destination channel 0..3
//   in_bit     - data bit to route
//   out_enable - demux enable (registered)
//   out_I      - demux data input (registered)
//   out_sel    - demux select (registered)
//   busy       - FIFO non-empty or a request is being presented
//   count      - current FIFO occupancy
module demux_route_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_dest,
   input  logic                     in_bit,
   output logic                     out_enable,
   output logic                     out_I,
   output logic [1:0]               out_sel,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t          state, state_d;
   logic [2:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [HW-1:0]   hold_cnt, hold_d;
   logic            en_d, i_d;
   logic [1:0]      sel_d;
   logic            push_c, pop_c;
   logic [2:0]      head_c;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign in_ready = !rst && (count != CW'(DEPTH));
   assign push_c   = in_valid && in_ready;
   assign head_c   = mem[rd_ptr];
   assign busy     = (state == DRIVE) || (count != '0);

   // FIFO storage; entries are {dest, bit}. Contents need no reset.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= {in_dest, in_bit};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // State, hold counter and registered demux controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         out_enable <= 1'b0;
         out_I      <= 1'b0;
         out_sel    <= 2'd0;
      end else begin
         state      <= state_d;
         hold_cnt   <= hold_d;
         out_enable <= en_d;
         out_I      <= i_d;
         out_sel    <= sel_d;
      end
   end

   // Next-state / next-output logic; pop decisions use registered count only.
   always_comb begin
      state_d = state;
      hold_d  = hold_cnt;
      en_d    = out_enable;
      i_d     = out_I;
      sel_d   = out_sel;
      pop_c   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop_c          = 1'b1;
               en_d           = 1'b1;
               {sel_d, i_d}   = head_c;
               hold_d         = HOLD_RELOAD;
               state_d        = DRIVE;
            end else begin
               en_d  = 1'b0;
               i_d   = 1'b0;
               sel_d = 2'd0;
            end
         end
         DRIVE: begin
            if (hold_cnt != '0) begin
               hold_d = hold_cnt - HW'(1);
            end else if (count != '0) begin
               pop_c          = 1'b1;
               en_d           = 1'b1;
               {sel_d, i_d}   = head_c;
               hold_d         = HOLD_RELOAD;
            end else begin
               en_d    = 1'b0;
               i_d     = 1'b0;
               sel_d   = 2'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_demux_route_scheduler.sv
// Bench for demux_route_scheduler: two instances (HOLD=1 and HOLD=3, DEPTH=4)
// checked every cycle against a queue-based model, plus literal expectations.
module tb_demux_route_scheduler;

   typedef struct {
      int         cyc;
      logic [2:0] req;
   } ev_t;

   logic       clk;
   logic [1:0] rs, v, b, rdy, en, oi, bsy;
   logic [1:0] d   [2];
   logic [1:0] sel [2];
   logic [2:0] cnt [2];

   int   tests = 0;
   int   fails = 0;
   int   cyc_n = 0;
   bit   chk_on = 0;
   ev_t  lg0[$];
   ev_t  lg1[$];

   demux_route_scheduler #(.DEPTH(4), .HOLD(1)) u_h1 (
      .clk(clk), .rst(rs[0]), .in_valid(v[0]), .in_ready(rdy[0]),
      .in_dest(d[0]), .in_bit(b[0]), .out_enable(en[0]), .out_I(oi[0]),
      .out_sel(sel[0]), .busy(bsy[0]), .count(cnt[0]));

   demux_route_scheduler #(.DEPTH(4), .HOLD(3)) u_h3 (
      .clk(clk), .rst(rs[1]), .in_valid(v[1]), .in_ready(rdy[1]),
      .in_dest(d[1]), .in_bit(b[1]), .out_enable(en[1]), .out_I(oi[1]),
      .out_sel(sel[1]), .busy(bsy[1]), .count(cnt[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Model: a request queue plus the request currently on the outputs and
   // how many presentation cycles it still has.
   for (genvar k = 0; k < 2; k++) begin : g_m
      localparam int H = (k == 0) ? 1 : 3;
      logic [2:0] mq[$];
      int         rem = 0;
      logic [2:0] cur = 3'd0;
      always @(posedge clk) begin
         bit acc;
         acc = v[k] && !rs[k] && (mq.size() < 4);
         if (rs[k]) begin
            mq.delete();
            rem = 0;
            cur = 3'd0;
         end else begin
            if (rem > 1) begin
               rem = rem - 1;
            end else if (mq.size() > 0) begin
               cur = mq.pop_front();
               rem = H;
            end else begin
               rem = 0;
               cur = 3'd0;
            end
            if (acc) mq.push_back({d[k], b[k]});
         end
      end
   end

   task automatic chk(input string nm, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, want);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("h1 out_enable", 32'(en[0]),  (g_m[0].rem > 0) ? 1 : 0);
         chk("h1 out_sel",    32'(sel[0]), 32'(g_m[0].cur[2:1]));
         chk("h1 out_I",      32'(oi[0]),  32'(g_m[0].cur[0]));
         chk("h1 count",      32'(cnt[0]), g_m[0].mq.size());
         chk("h1 busy",       32'(bsy[0]), (g_m[0].rem > 0 || g_m[0].mq.size() > 0) ? 1 : 0);
         chk("h1 in_ready",   32'(rdy[0]), (!rs[0] && g_m[0].mq.size() != 4) ? 1 : 0);
         chk("h3 out_enable", 32'(en[1]),  (g_m[1].rem > 0) ? 1 : 0);
         chk("h3 out_sel",    32'(sel[1]), 32'(g_m[1].cur[2:1]));
         chk("h3 out_I",      32'(oi[1]),  32'(g_m[1].cur[0]));
         chk("h3 count",      32'(cnt[1]), g_m[1].mq.size());
         chk("h3 busy",       32'(bsy[1]), (g_m[1].rem > 0 || g_m[1].mq.size() > 0) ? 1 : 0);
         chk("h3 in_ready",   32'(rdy[1]), (!rs[1] && g_m[1].mq.size() != 4) ? 1 : 0);
      end
   end

   // Presentation log per instance.
   always @(negedge clk) begin
      if (en[0] === 1'b1) lg0.push_back('{cyc_n, {sel[0], oi[0]}});
      if (en[1] === 1'b1) lg1.push_back('{cyc_n, {sel[1], oi[1]}});
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      logic [2:0] brq [4];
      logic [2:0] rq  [6];
      logic [2:0] sq  [6];
      int  idx;
      int  s0;
      bit  acc;
      bit  saw_full;

      brq = '{3'b001, 3'b010, 3'b101, 3'b111};
      rq  = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd1, 3'd2};
      sq  = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd6, 3'd3};

      // Reset for two cycles with requests offered.
      rs = 2'b11; v = 2'b11; b = 2'b11; d[0] = 2'd1; d[1] = 2'd2;
      cyc(1);
      chk_on = 1'b1;
      chk("rst in_ready h1", 32'(rdy[0]), 0);
      chk("rst in_ready h3", 32'(rdy[1]), 0);
      chk("rst count h1",    32'(cnt[0]), 0);
      cyc(1);
      chk("rst out_enable h3", 32'(en[1]), 0);
      rs = 2'b00; v = 2'b00;
      #1;
      chk("post-rst in_ready h1", 32'(rdy[0]), 1);
      chk("post-rst count h3",    32'(cnt[1]), 0);
      chk("post-rst busy h1",     32'(bsy[0]), 0);
      cyc(3);

      // Single request, HOLD=1.
      v[0] = 1'b1; d[0] = 2'd2; b[0] = 1'b1;
      cyc(1);
      v[0] = 1'b0;
      cyc(1);
      chk("single en",  32'(en[0]),  1);
      chk("single sel", 32'(sel[0]), 2);
      chk("single I",   32'(oi[0]),  1);
      cyc(1);
      chk("single en off",   32'(en[0]),  0);
      chk("single sel off",  32'(sel[0]), 0);
      chk("single I off",    32'(oi[0]),  0);
      chk("single busy off", 32'(bsy[0]), 0);
      cyc(3);

      // Burst of four, HOLD=1.
      lg0.delete();
      for (int i = 0; i < 4; i++) begin
         v[0] = 1'b1; {d[0], b[0]} = brq[i];
         cyc(1);
      end
      v[0] = 1'b0;
      cyc(6);
      chk("burst log size", lg0.size(), 4);
      for (int i = 0; i < 4 && i < lg0.size(); i++) begin
         chk("burst req", 32'(lg0[i].req), 32'(brq[i]));
         chk("burst contiguous", lg0[i].cyc, lg0[0].cyc + i);
      end

      // Backpressure with wrap-around, HOLD=3.
      lg1.delete();
      idx = 0; saw_full = 1'b0;
      for (int s = 0; s < 8; s++) begin
         v[1] = 1'b1; {d[1], b[1]} = rq[(idx < 6) ? idx : 5];
         #1;
         acc = rdy[1];
         if (cnt[1] == 3'd4 && rdy[1] == 1'b0) saw_full = 1'b1;
         cyc(1);
         if (acc) idx++;
      end
      v[1] = 1'b0;
      cyc(25);
      chk("full accepted", idx, 6);
      chk("full ready dropped", 32'(saw_full), 1);
      chk("full log size", lg1.size(), 18);
      for (int i = 0; i < 18 && i < lg1.size(); i++) begin
         chk("full req", 32'(lg1[i].req), 32'(rq[i / 3]));
         chk("full contiguous", lg1[i].cyc, lg1[0].cyc + i);
      end

      // Reset during the second hold cycle with two entries queued, HOLD=3.
      lg1.delete();
      v[1] = 1'b1; {d[1], b[1]} = 3'b011;
      cyc(1);
      {d[1], b[1]} = 3'b100;
      cyc(1);
      {d[1], b[1]} = 3'b110;
      cyc(1);
      v[1] = 1'b0;
      chk("midrst queued", 32'(cnt[1]), 2);
      rs[1] = 1'b1;
      cyc(1);
      rs[1] = 1'b0;
      chk("midrst en",    32'(en[1]),  0);
      chk("midrst sel",   32'(sel[1]), 0);
      chk("midrst I",     32'(oi[1]),  0);
      chk("midrst count", 32'(cnt[1]), 0);
      chk("midrst busy",  32'(bsy[1]), 0);
      cyc(10);
      chk("midrst log size", lg1.size(), 2);
      for (int i = 0; i < lg1.size(); i++) begin
         chk("midrst only first", 32'(lg1[i].req), 3);
      end

      // Simultaneous push and pop every cycle, HOLD=1.
      lg0.delete();
      s0 = cyc_n;
      for (int i = 0; i < 6; i++) begin
         v[0] = 1'b1; {d[0], b[0]} = sq[i];
         cyc(1);
         chk("sim count", 32'(cnt[0]), 1);
      end
      v[0] = 1'b0;
      cyc(6);
      chk("sim log size", lg0.size(), 6);
      for (int i = 0; i < 6 && i < lg0.size(); i++) begin
         chk("sim req", 32'(lg0[i].req), 32'(sq[i]));
         chk("sim delay", lg0[i].cyc, s0 + 2 + i);
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
